// File: rtl/fir_mc_mac_engine.sv
// Multi-channel FIR engine built around one serial multiply-accumulator.
// All channels share one coefficient set; each channel has its own circular
// delay line and head pointer. A sample is accepted in IDLE, convolved over
// N cycles in MAC, and the scaled, saturated result is held in OUT until taken.
module fir_mc_mac_engine #(
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_TAPS    = 64,
    parameter int NB_CHANNELS = 4,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH + $clog2(MAX_TAPS)
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_i,
    input  logic                                                   clear_i,
    input  logic [$clog2(MAX_TAPS+1)-1:0]                          cfg_nb_taps_i,
    input  logic [$clog2(ACC_WIDTH)-1:0]                           cfg_shift_i,
    input  logic                                                   cfg_round_i,
    input  logic                                                   h_valid_i,
    output logic                                                   h_ready_o,
    input  logic [DATA_WIDTH-1:0]                                  h_data_i,
    input  logic                                                   x_valid_i,
    output logic                                                   x_ready_o,
    input  logic [DATA_WIDTH-1:0]                                  x_data_i,
    input  logic [((NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1)-1:0] x_chan_i,
    output logic                                                   y_valid_o,
    input  logic                                                   y_ready_i,
    output logic [DATA_WIDTH-1:0]                                  y_data_o,
    output logic [((NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1)-1:0] y_chan_o,
    output logic                                                   busy_o,
    output logic                                                   coeff_loaded_o
);

    localparam int NW = $clog2(MAX_TAPS+1);
    localparam int SW = $clog2(ACC_WIDTH);
    localparam int CW = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1;
    localparam int AW = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
    localparam int PW = 2*DATA_WIDTH;

    localparam logic signed [ACC_WIDTH:0] SAT_MAX = {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0]     OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]     OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Round-half-up, arithmetic shift and clamp to the output range.
    // Shifts beyond ACC_WIDTH give the same result as ACC_WIDTH, so the
    // shift is clamped there to keep the rounding constant representable.
    function automatic logic [DATA_WIDTH-1:0] scale_sat(
        input logic signed [ACC_WIDTH-1:0] acc,
        input logic        [SW-1:0]        sh,
        input logic                        rnd
    );
        logic        [SW:0]        sh_c;
        logic signed [ACC_WIDTH:0] rv;
        logic signed [ACC_WIDTH:0] sum;
        logic signed [ACC_WIDTH:0] shd;
        if ({1'b0, sh} > (SW+1)'(ACC_WIDTH)) begin
            sh_c = (SW+1)'(ACC_WIDTH);
        end else begin
            sh_c = {1'b0, sh};
        end
        if (rnd && (sh_c != '0)) begin
            rv = (ACC_WIDTH+1)'(1) << (sh_c - (SW+1)'(1));
        end else begin
            rv = '0;
        end
        sum = {acc[ACC_WIDTH-1], acc} + rv;
        shd = sum >>> sh_c;
        if (shd > SAT_MAX) begin
            return OUT_MAX;
        end else if (shd < SAT_MIN) begin
            return OUT_MIN;
        end else begin
            return shd[DATA_WIDTH-1:0];
        end
    endfunction

    // Storage
    logic [DATA_WIDTH-1:0] coeff_q [MAX_TAPS];
    logic [DATA_WIDTH-1:0] dl_q    [NB_CHANNELS][MAX_TAPS];
    logic [AW-1:0]         head_q  [NB_CHANNELS];

    // Control / output registers and next-state values
    state_t                       state_q,   state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q,     acc_d;
    logic        [AW-1:0]         tap_q,     tap_d;
    logic        [CW-1:0]         ch_q,      ch_d;
    logic        [SW-1:0]         shift_q,   shift_d;
    logic                         round_q,   round_d;
    logic        [AW-1:0]         hptr_q,    hptr_d;
    logic        [NW-1:0]         n_q,       n_d;
    logic                         loaded_q,  loaded_d;
    logic                         y_valid_q, y_valid_d;
    logic        [DATA_WIDTH-1:0] y_data_q,  y_data_d;
    logic        [CW-1:0]         y_chan_q,  y_chan_d;
    logic                         x_ready_q, x_ready_d;
    logic                         h_ready_q, h_ready_d;
    logic                         busy_q,    busy_d;

    // Combinational helpers
    logic                        h_fire_s;
    logic                        x_fire_s;
    logic [CW-1:0]               x_ch_s;
    logic [NW-1:0]               n_cfg_s;
    logic [NW-1:0]               n_eff_s;
    logic                        hptr_last_s;
    logic                        last_tap_s;
    logic [AW-1:0]               head_cur_s;
    logic [AW-1:0]               head_inc_s;
    logic [AW-1:0]               rd_idx_s;
    logic signed [PW-1:0]        coef_ext_s;
    logic signed [PW-1:0]        samp_ext_s;
    logic signed [PW-1:0]        prod_s;
    logic signed [ACC_WIDTH-1:0] prod_ext_s;
    logic signed [ACC_WIDTH-1:0] acc_sum_s;

    assign h_ready_o      = h_ready_q;
    assign x_ready_o      = x_ready_q;
    assign y_valid_o      = y_valid_q;
    assign y_data_o       = y_data_q;
    assign y_chan_o       = y_chan_q;
    assign busy_o         = busy_q;
    assign coeff_loaded_o = loaded_q;

    assign h_fire_s = h_valid_i && h_ready_q;
    assign x_fire_s = x_valid_i && x_ready_q;

    // Out-of-range channel indices fold onto channel 0.
    generate
        if (NB_CHANNELS == (1 << CW)) begin : g_chan_full
            assign x_ch_s = x_chan_i;
        end else begin : g_chan_map
            assign x_ch_s = (int'(x_chan_i) >= NB_CHANNELS) ? '0 : x_chan_i;
        end
    endgenerate

    // Tap count clamp, coefficient pointer terminal count and tap counter end.
    always_comb begin
        if (cfg_nb_taps_i == '0) begin
            n_cfg_s = NW'(1);
        end else if (cfg_nb_taps_i > NW'(MAX_TAPS)) begin
            n_cfg_s = NW'(MAX_TAPS);
        end else begin
            n_cfg_s = cfg_nb_taps_i;
        end
        if (hptr_q == '0) begin
            n_eff_s = n_cfg_s;
        end else begin
            n_eff_s = n_q;
        end
        hptr_last_s = (NW'(hptr_q) == (n_eff_s - NW'(1)));
        last_tap_s  = (state_q == MAC) && (NW'(tap_q) == (n_q - NW'(1)));
    end

    // Circular delay-line addressing for the active channel.
    always_comb begin
        head_cur_s = head_q[ch_q];
        if (head_cur_s >= tap_q) begin
            rd_idx_s = head_cur_s - tap_q;
        end else begin
            rd_idx_s = AW'((AW+1)'(MAX_TAPS) + (AW+1)'(head_cur_s) - (AW+1)'(tap_q));
        end
        if (head_cur_s == AW'(MAX_TAPS-1)) begin
            head_inc_s = '0;
        end else begin
            head_inc_s = head_cur_s + AW'(1);
        end
    end

    // Single full-width signed product accumulated into the wide accumulator.
    always_comb begin
        coef_ext_s = {{DATA_WIDTH{coeff_q[tap_q][DATA_WIDTH-1]}}, coeff_q[tap_q]};
        samp_ext_s = {{DATA_WIDTH{dl_q[ch_q][rd_idx_s][DATA_WIDTH-1]}}, dl_q[ch_q][rd_idx_s]};
        prod_s     = coef_ext_s * samp_ext_s;
        prod_ext_s = {{(ACC_WIDTH-PW){prod_s[PW-1]}}, prod_s};
        acc_sum_s  = acc_q + prod_ext_s;
    end

    // Next-state logic for the FSM, the loader and the output registers.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        tap_d     = tap_q;
        ch_d      = ch_q;
        shift_d   = shift_q;
        round_d   = round_q;
        hptr_d    = hptr_q;
        n_d       = n_q;
        loaded_d  = loaded_q;
        y_valid_d = y_valid_q;
        y_data_d  = y_data_q;
        y_chan_d  = y_chan_q;
        case (state_q)
            IDLE: begin
                if (h_fire_s) begin
                    n_d = n_eff_s;
                    if (hptr_last_s) begin
                        loaded_d = 1'b1;
                        hptr_d   = '0;
                    end else begin
                        loaded_d = 1'b0;
                        hptr_d   = hptr_q + AW'(1);
                    end
                end else begin
                    hptr_d = hptr_q;
                end
                if (x_fire_s) begin
                    state_d = MAC;
                    acc_d   = '0;
                    tap_d   = '0;
                    ch_d    = x_ch_s;
                    shift_d = cfg_shift_i;
                    round_d = cfg_round_i;
                end else begin
                    state_d = IDLE;
                end
            end
            MAC: begin
                acc_d = acc_sum_s;
                if (last_tap_s) begin
                    state_d   = OUT;
                    tap_d     = '0;
                    y_valid_d = 1'b1;
                    y_data_d  = scale_sat(acc_sum_s, shift_q, round_q);
                    y_chan_d  = ch_q;
                end else begin
                    state_d = MAC;
                    tap_d   = tap_q + AW'(1);
                end
            end
            OUT: begin
                if (y_ready_i) begin
                    state_d   = IDLE;
                    y_valid_d = 1'b0;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d   = IDLE;
                y_valid_d = 1'b0;
            end
        endcase
        x_ready_d = (state_d == IDLE) && loaded_d;
        h_ready_d = (state_d == IDLE) && !loaded_d;
        busy_d    = (state_d != IDLE);
    end

    // FSM, datapath and output registers; clear_i behaves as a synchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            tap_q     <= '0;
            ch_q      <= '0;
            shift_q   <= '0;
            round_q   <= 1'b0;
            hptr_q    <= '0;
            n_q       <= NW'(1);
            loaded_q  <= 1'b0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_chan_q  <= '0;
            x_ready_q <= 1'b0;
            h_ready_q <= 1'b1;
            busy_q    <= 1'b0;
        end else if (clear_i) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            tap_q     <= '0;
            ch_q      <= '0;
            shift_q   <= '0;
            round_q   <= 1'b0;
            hptr_q    <= '0;
            n_q       <= NW'(1);
            loaded_q  <= 1'b0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_chan_q  <= '0;
            x_ready_q <= 1'b0;
            h_ready_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            tap_q     <= tap_d;
            ch_q      <= ch_d;
            shift_q   <= shift_d;
            round_q   <= round_d;
            hptr_q    <= hptr_d;
            n_q       <= n_d;
            loaded_q  <= loaded_d;
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            y_chan_q  <= y_chan_d;
            x_ready_q <= x_ready_d;
            h_ready_q <= h_ready_d;
            busy_q    <= busy_d;
        end
    end

    // Coefficient memory: zeroed by reset only, written by accepted h beats.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_TAPS; i++) begin
                coeff_q[i] <= '0;
            end
        end else if (h_fire_s && !clear_i) begin
            coeff_q[hptr_q] <= h_data_i;
        end
    end

    // Per-channel delay lines and head pointers; cleared by reset and clear_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NB_CHANNELS; c++) begin
                head_q[c] <= '0;
                for (int i = 0; i < MAX_TAPS; i++) begin
                    dl_q[c][i] <= '0;
                end
            end
        end else if (clear_i) begin
            for (int c = 0; c < NB_CHANNELS; c++) begin
                head_q[c] <= '0;
                for (int i = 0; i < MAX_TAPS; i++) begin
                    dl_q[c][i] <= '0;
                end
            end
        end else begin
            if (x_fire_s) begin
                dl_q[x_ch_s][head_q[x_ch_s]] <= x_data_i;
            end
            if (last_tap_s) begin
                head_q[ch_q] <= head_inc_s;
            end
        end
    end

endmodule

// File: tb/tb_fir_mc_mac_engine.sv
// Self-checking bench for fir_mc_mac_engine: directed vector table, manual
// backpressure / clear / reset sequences, and randomized traffic compared
// against a queue-based convolution model.
module tb_fir_mc_mac_engine;

    localparam int DW = 16;
    localparam int MT = 64;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [6:0]  cfg_nb_taps;
    logic [5:0]  cfg_shift;
    logic        cfg_round;
    logic        h_valid;
    logic        h_ready;
    logic [15:0] h_data;
    logic        x_valid;
    logic        x_ready;
    logic [15:0] x_data;
    logic [1:0]  x_chan;
    logic        y_valid;
    logic        y_ready;
    logic [15:0] y_data;
    logic [1:0]  y_chan;
    logic        busy;
    logic        loaded;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fir_mc_mac_engine dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clear_i        (clear),
        .cfg_nb_taps_i  (cfg_nb_taps),
        .cfg_shift_i    (cfg_shift),
        .cfg_round_i    (cfg_round),
        .h_valid_i      (h_valid),
        .h_ready_o      (h_ready),
        .h_data_i       (h_data),
        .x_valid_i      (x_valid),
        .x_ready_o      (x_ready),
        .x_data_i       (x_data),
        .x_chan_i       (x_chan),
        .y_valid_o      (y_valid),
        .y_ready_i      (y_ready),
        .y_data_o       (y_data),
        .y_chan_o       (y_chan),
        .busy_o         (busy),
        .coeff_loaded_o (loaded)
    );

    typedef struct {
        int ch;
        int x;
        int sh;
        bit rnd;
        int exp_y;
    } vec_t;

    vec_t vt [26];

    // Reference model state
    int m_coef [MT];
    int m_n;
    int m_hist [NC][$];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_y(input int ch, input int sh, input bit rnd);
        longint acc = 0;
        for (int k = 0; k < m_n; k++) begin
            if (k < m_hist[ch].size()) acc += longint'(m_coef[k]) * longint'(m_hist[ch][k]);
        end
        if (rnd && sh > 0) acc += longint'(1) << (sh - 1);
        acc = acc >>> sh;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    task automatic model_push(input int ch, input int x);
        m_hist[ch].push_front(x);
        if (m_hist[ch].size() > MT) void'(m_hist[ch].pop_back());
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int c = 0; c < NC; c++) m_hist[c].delete();
    endtask

    task automatic load_coeffs(input int cfg_n, input int n, input int c [MT], input bit chk_partial);
        int g;
        cfg_nb_taps = 7'(cfg_n);
        for (int i = 0; i < n; i++) begin
            h_valid = 1'b1;
            h_data  = 16'(c[i]);
            g = 0;
            while (!h_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g >= 50) check("h_ready_timeout", 0, 1);
            if (chk_partial && (i == 0 || i == n - 1)) check("loaded_before_done", loaded, 0);
            @(posedge clk);
            @(negedge clk);
        end
        h_valid = 1'b0;
        check("coeff_loaded", loaded, 1);
        check("h_ready_after_load", h_ready, 0);
        m_n = n;
        for (int i = 0; i < MT; i++) m_coef[i] = c[i];
    endtask

    task automatic send_sample(input int ch, input int x, input int sh, input bit rnd,
                               output int y, output int ych, output int lat, output int hs);
        int g;
        cfg_shift = 6'(sh);
        cfg_round = rnd;
        x_chan    = 2'(ch);
        x_data    = 16'(x);
        x_valid   = 1'b1;
        g = 0;
        while (!x_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) check("x_ready_timeout", 0, 1);
        @(posedge clk);
        hs = cyc;
        @(negedge clk);
        x_valid   = 1'b0;
        cfg_shift = 6'($urandom);
        cfg_round = 1'($urandom);
        lat = 1;
        while (!y_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!y_valid) check("y_valid_timeout", 0, 1);
        y   = int'($signed(y_data));
        ych = int'(y_chan);
    endtask

    task automatic run_table(input int first, input int last, input int n);
        int y, ych, lat, hs, prev_hs;
        prev_hs = 0;
        for (int i = first; i <= last; i++) begin
            send_sample(vt[i].ch, vt[i].x, vt[i].sh, vt[i].rnd, y, ych, lat, hs);
            check($sformatf("vec%0d_y", i), y, vt[i].exp_y);
            check($sformatf("vec%0d_chan", i), ych, vt[i].ch);
            check($sformatf("vec%0d_latency", i), lat, n + 1);
            if (i > first) check($sformatf("vec%0d_period", i), hs - prev_hs, n + 2);
            prev_hs = hs;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_y_valid"}, y_valid, 0);
        check({tag, "_y_data"},  y_data, 0);
        check({tag, "_y_chan"},  y_chan, 0);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_loaded"},  loaded, 0);
        check({tag, "_x_ready"}, x_ready, 0);
        check({tag, "_h_ready"}, h_ready, 1);
    endtask

    task automatic start_mac_then_wait(input int ch, input int x);
        int g;
        x_valid = 1'b1;
        x_data  = 16'(x);
        x_chan  = 2'(ch);
        g = 0;
        while (!x_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) check("mid_mac_x_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        x_valid = 1'b0;
        @(negedge clk);
        check("mid_mac_busy", busy, 1);
    endtask

    int h1234 [MT];
    int hmax  [MT];
    int hone  [MT];
    int hrnd  [MT];

    initial begin
        int y, ych, lat, hs, g, exp_y, cfg_n, n, ch, x, sh;
        bit rnd;
        int cfg_list [6];
        logic [15:0] held_data;
        logic [1:0]  held_chan;

        rst = 1'b1; clear = 1'b0; cfg_nb_taps = 7'd4; cfg_shift = 6'd0; cfg_round = 1'b0;
        h_valid = 1'b0; h_data = 16'd0; x_valid = 1'b0; x_data = 16'd0; x_chan = 2'd0;
        y_ready = 1'b1;
        for (int i = 0; i < MT; i++) begin
            h1234[i] = 0; hmax[i] = 0; hone[i] = 0; hrnd[i] = 0;
        end
        h1234[0] = 1; h1234[1] = 2; h1234[2] = 3; h1234[3] = 4;
        for (int i = 0; i < 4; i++) hmax[i] = 32767;
        hone[0] = 1;

        // Directed vector table: {ch, x, shift, round, expected y}
        vt[0]  = '{0, 1, 0, 1'b0, 1};
        vt[1]  = '{0, 0, 0, 1'b0, 2};
        vt[2]  = '{0, 0, 0, 1'b0, 3};
        vt[3]  = '{0, 0, 0, 1'b0, 4};
        vt[4]  = '{0, 0, 0, 1'b0, 0};
        vt[5]  = '{0, 1, 0, 1'b0, 1};
        vt[6]  = '{1, 10, 0, 1'b0, 10};
        vt[7]  = '{0, 0, 0, 1'b0, 2};
        vt[8]  = '{1, 10, 0, 1'b0, 30};
        vt[9]  = '{0, 0, 0, 1'b0, 3};
        vt[10] = '{1, 10, 0, 1'b0, 60};
        vt[11] = '{0, 0, 0, 1'b0, 4};
        vt[12] = '{1, 10, 0, 1'b0, 100};
        for (int i = 13; i <= 16; i++) vt[i] = '{3, 32767, 0, 1'b0, 32767};
        for (int i = 17; i <= 20; i++) vt[i] = '{2, -32768, 0, 1'b0, -32768};
        vt[21] = '{0, 6, 2, 1'b1, 2};
        vt[22] = '{0, 5, 2, 1'b1, 1};
        vt[23] = '{1, -6, 2, 1'b1, -1};
        vt[24] = '{0, 7, 2, 1'b0, 1};
        vt[25] = '{2, -1, 2, 1'b0, -1};

        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Impulse response
        load_coeffs(4, 4, h1234, 1'b1);
        run_table(0, 4, 4);

        // Channel isolation
        do_clear();
        load_coeffs(4, 4, h1234, 1'b0);
        run_table(5, 12, 4);

        // Saturation, positive then negative
        do_clear();
        load_coeffs(4, 4, hmax, 1'b0);
        run_table(13, 16, 4);
        do_clear();
        load_coeffs(4, 4, hmax, 1'b0);
        run_table(17, 20, 4);

        // Rounding with a single tap
        do_clear();
        load_coeffs(1, 1, hone, 1'b0);
        run_table(21, 25, 1);

        // Backpressure
        do_clear();
        load_coeffs(4, 4, h1234, 1'b0);
        y_ready = 1'b0;
        send_sample(2, 5, 0, 1'b0, y, ych, lat, hs);
        check("bp_first_y", y, 5);
        check("bp_first_chan", ych, 2);
        held_data = y_data;
        held_chan = y_chan;
        x_valid = 1'b1; x_data = 16'd7; x_chan = 2'd2; cfg_shift = 6'd0; cfg_round = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_y_data_stable", y_data, held_data);
            check("bp_y_chan_stable", y_chan, held_chan);
            check("bp_y_valid_held", y_valid, 1);
            check("bp_x_ready_low", x_ready, 0);
            check("bp_busy_high", busy, 1);
        end
        y_ready = 1'b1;
        @(negedge clk);
        check("bp_x_ready_after_hs", x_ready, 1);
        check("bp_y_valid_dropped", y_valid, 0);
        @(posedge clk);
        @(negedge clk);
        x_valid = 1'b0;
        check("bp_next_accepted", busy, 1);
        lat = 1;
        while (!y_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bp_second_latency", lat, 5);
        check("bp_second_y", int'($signed(y_data)), 17);
        @(negedge clk);

        // Clear during MAC, reload, rerun impulse
        start_mac_then_wait(0, 9);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int c = 0; c < NC; c++) m_hist[c].delete();
        for (int i = 0; i < 8; i++) begin
            check("clr_no_stale_y", y_valid, 0);
            check("clr_loaded_low", loaded, 0);
            check("clr_busy_low", busy, 0);
            @(negedge clk);
        end
        load_coeffs(4, 4, h1234, 1'b1);
        run_table(0, 4, 4);
        @(negedge clk);

        // Asynchronous reset during MAC, reload, rerun impulse
        start_mac_then_wait(0, 9);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int c = 0; c < NC; c++) m_hist[c].delete();
        for (int i = 0; i < 8; i++) begin
            check("rst_no_stale_y", y_valid, 0);
            check("rst_loaded_low", loaded, 0);
            @(negedge clk);
        end
        load_coeffs(4, 4, h1234, 1'b1);
        run_table(0, 4, 4);
        @(negedge clk);

        // Randomized traffic against the convolution model
        cfg_list[0] = 0;   cfg_list[1] = 3;  cfg_list[2] = 7;
        cfg_list[3] = 100; cfg_list[4] = 2;  cfg_list[5] = 64;
        for (int it = 0; it < 6; it++) begin
            do_clear();
            cfg_n = cfg_list[it];
            n = (cfg_n < 1) ? 1 : ((cfg_n > MT) ? MT : cfg_n);
            for (int i = 0; i < MT; i++) begin
                hrnd[i] = (i < n) ? (int'($urandom_range(0, 65535)) - 32768) : 0;
            end
            if (it == 1) for (int i = 0; i < n; i++) hrnd[i] = int'($urandom_range(0, 40)) - 20;
            load_coeffs(cfg_n, n, hrnd, 1'b0);
            for (int s = 0; s < 25; s++) begin
                ch  = int'($urandom_range(0, NC - 1));
                x   = int'($urandom_range(0, 65535)) - 32768;
                if (it == 1) x = int'($urandom_range(0, 200)) - 100;
                sh  = int'($urandom_range(0, 20));
                rnd = 1'($urandom);
                model_push(ch, x);
                exp_y = model_y(ch, sh, rnd);
                send_sample(ch, x, sh, rnd, y, ych, lat, hs);
                check($sformatf("rnd%0d_%0d_y", it, s), y, exp_y);
                check($sformatf("rnd%0d_%0d_chan", it, s), ych, ch);
                check($sformatf("rnd%0d_%0d_latency", it, s), lat, n + 1);
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
